// File: rtl/mcp_tx_fifo.sv
// First-word-fall-through buffer in front of the MCP sender. It absorbs producer bursts
// and presents one head word at a time on the asend/aready handshake.
module mcp_tx_fifo #(
   parameter int DWIDTH       = 32,
   parameter int DEPTH_LOG    = 3,
   parameter int AFULL_THRESH = 6,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                 clk,
   input  logic                 rstb,
   input  logic                 flush,
   input  logic [DWIDTH-1:0]    in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [DWIDTH-1:0]    out_data,
   output logic                 out_send,
   input  logic                 out_ready,
   output logic [DEPTH_LOG:0]   count,
   output logic                 almost_full,
   output logic [CNT_WIDTH-1:0] sent_cnt
);

   localparam int                 DEPTH     = 1 << DEPTH_LOG;
   localparam logic [DEPTH_LOG:0] FULL_CNT  = (DEPTH_LOG+1)'(DEPTH);
   localparam logic [DEPTH_LOG:0] AFULL_CNT = (DEPTH_LOG+1)'(AFULL_THRESH);
   localparam logic [DEPTH_LOG:0] CNT_ONE   = (DEPTH_LOG+1)'(1);
   localparam logic [DEPTH_LOG-1:0] PTR_ONE = DEPTH_LOG'(1);
   localparam logic [CNT_WIDTH-1:0] SENT_ONE = CNT_WIDTH'(1);

   logic [DWIDTH-1:0]    mem [DEPTH];
   logic [DEPTH_LOG-1:0] wp;
   logic [DEPTH_LOG-1:0] rp;
   logic                 push;
   logic                 pop;

   // Handshake flags come only from registered occupancy, never from out_ready or in_valid.
   assign in_ready    = (count != FULL_CNT);
   assign out_send    = (count != '0);
   assign almost_full = (count >= AFULL_CNT);
   assign out_data    = mem[rp];
   assign push        = in_valid & in_ready & ~flush;
   assign pop         = out_send & out_ready & ~flush;

   // NOTE: the storage array has no reset; stale words are never visible while out_send=0.
   always_ff @(posedge clk) begin
      if (push) mem[wp] <= in_data;
   end

   // NOTE: non-blocking assignments keep every register sampling pre-edge values.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         wp       <= '0;
         rp       <= '0;
         count    <= '0;
         sent_cnt <= '0;
      end else if (flush) begin
         wp       <= '0;
         rp       <= '0;
         count    <= '0;
         sent_cnt <= '0;
      end else begin
         if (push) wp <= wp + PTR_ONE;
         if (pop) begin
            rp       <= rp + PTR_ONE;
            sent_cnt <= sent_cnt + SENT_ONE;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_mcp_tx_fifo.sv
// Directed self-checking bench for mcp_tx_fifo with default parameters (DEPTH=8, threshold 6).
module tb_mcp_tx_fifo;

   logic        clk = 1'b0;
   logic        rstb;
   logic        flush;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out_data;
   logic        out_send;
   logic        out_ready;
   logic [3:0]  count;
   logic        almost_full;
   logic [15:0] sent_cnt;

   int errors = 0;
   int checks = 0;

   mcp_tx_fifo dut (
      .clk         (clk),
      .rstb        (rstb),
      .flush       (flush),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_data    (out_data),
      .out_send    (out_send),
      .out_ready   (out_ready),
      .count       (count),
      .almost_full (almost_full),
      .sent_cnt    (sent_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge and settle so outputs reflect that edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rstb      = 1'b0;
      flush     = 1'b0;
      in_data   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #12;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_send", out_send, 0);
      check("rst_afull", almost_full, 0);
      check("rst_count", count, 0);
      check("rst_sent", sent_cnt, 0);
      rstb = 1'b1;
      tick();

      // Single word through
      in_data = 32'hA5A5_0001; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("one_send", out_send, 1);
      check("one_data", out_data, 32'hA5A5_0001);
      check("one_count", count, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("one_pop_count", count, 0);
      check("one_pop_send", out_send, 0);
      check("one_pop_sent", sent_cnt, 1);

      // Fill to full, watching almost_full threshold
      for (int i = 0; i < 8; i++) begin
         in_data = 32'h10 + i; in_valid = 1'b1;
         tick();
         check($sformatf("fill_count%0d", i), count, i + 1);
         check($sformatf("fill_afull%0d", i), almost_full, (i + 1 >= 6) ? 1 : 0);
      end
      check("full_in_ready", in_ready, 0);
      in_data = 32'h18;
      tick();
      check("full_hold_count", count, 8);
      check("full_head", out_data, 32'h10);

      // Full with simultaneous push attempt and pop: only the pop happens
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("fullpop_count", count, 7);
      check("fullpop_head", out_data, 32'h11);
      check("fullpop_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      check("refill_count", count, 8);
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         check($sformatf("drain%0d", k), out_data, 32'h11 + k);
         tick();
      end
      out_ready = 1'b0;
      check("drain_count", count, 0);
      check("drain_send", out_send, 0);
      check("drain_sent", sent_cnt, 10);

      // Flush with concurrent push and pop
      for (int i = 0; i < 5; i++) begin
         in_data = 32'h20 + i; in_valid = 1'b1;
         tick();
      end
      check("preflush_count", count, 5);
      in_data = 32'hDEAD_BEEF; out_ready = 1'b1; flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      check("flush_count", count, 0);
      check("flush_send", out_send, 0);
      check("flush_sent", sent_cnt, 0);
      check("flush_ready", in_ready, 1);
      in_data = 32'h30; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("postflush_head", out_data, 32'h30);
      check("postflush_count", count, 1);

      // Loopback stream of 20 words with out_ready held high
      flush = 1'b1;
      tick();
      flush = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_data = 32'h100 + i; in_valid = 1'b1;
         tick();
         check($sformatf("stream%0d", i), out_data, 32'h100 + i);
      end
      in_valid = 1'b0;
      tick();
      out_ready = 1'b0;
      check("stream_sent", sent_cnt, 20);
      check("stream_count", count, 0);

      // Asynchronous reset mid-burst
      for (int i = 0; i < 4; i++) begin
         in_data = 32'h40 + i; in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      check("prerst_count", count, 4);
      #2 rstb = 1'b0;
      #1;
      check("arst_count", count, 0);
      check("arst_send", out_send, 0);
      check("arst_ready", in_ready, 1);
      check("arst_sent", sent_cnt, 0);
      #1 rstb = 1'b1;
      in_data = 32'h50; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("postrst_head", out_data, 32'h50);
      check("postrst_count", count, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
